// File: rtl/tff_count_pkg.sv
// Shared helpers for the toggle-cell mod-N counter: direction constants and the next-state rule.
// TFF_COUNT_CTRL_SAT_EN selects saturation at the range limits instead of wrap-around.
package tff_count_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned next_count(input int unsigned count,
                                             input logic        up,
                                             input int unsigned modulus);
    int unsigned r;
    if (up == DIR_UP) begin
      if (count >= modulus - 1) begin
`ifdef TFF_COUNT_CTRL_SAT_EN
        r = count;
`else
        r = 0;
`endif
      end else begin
        r = count + 1;
      end
    end else begin
      if (count == 0) begin
`ifdef TFF_COUNT_CTRL_SAT_EN
        r = 0;
`else
        r = modulus - 1;
`endif
      end else begin
        r = count - 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with synchronous active-low reset; one bit of the counter state.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Mod-N up/down counter built from toggle cells; exports the per-bit toggle vector and terminal count.
// Define TFF_COUNT_CTRL_SAT_EN to saturate at the range limits instead of wrapping.
module tff_count_ctrl
  import tff_count_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] t_vec;
  logic             tc_c;
  logic             wrap_d;
  logic             wrap_q;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (32'(v) < MODULUS) return v;
    else                  return MAX_C;
  endfunction

  // The toggle vector is derived from the desired next value, so the cell bank
  // (and any external mirror bank) lands exactly on next_val at the edge.
  always_comb begin
    next_val = count_q;
    tc_c     = 1'b0;
    if (!rst_n) begin
      next_val = count_q;
    end else if (load) begin
      next_val = clamp_load(load_val);
    end else if (en) begin
      next_val = WIDTH'(next_count(32'(count_q), up, MODULUS));
      tc_c     = (count_q == ((up == DIR_UP) ? MAX_C : '0));
    end
    t_vec = rst_n ? (count_q ^ next_val) : '0;
  end

  always_comb begin
`ifdef TFF_COUNT_CTRL_SAT_EN
    wrap_d = 1'b0;
`else
    wrap_d = tc_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .q     (count_q[i])
    );
  end

  assign count = count_q;
  assign t_out = t_vec;
  assign tc    = tc_c;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench for tff_count_ctrl (WIDTH=4, MODULUS=10): directed plan plus randomized traffic.
module tb_tff_count_ctrl;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst_n, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count, t_out;
  logic         tc, wrap;

  tff_count_ctrl #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .t_out(t_out), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    count;
    int    t_out;
    int    tc;
    int    wrap;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: value of the counter and the wrap flag as seen in the current cycle.
  int m_count = 0;
  int m_wrap  = 0;

  task automatic chk(input string name, input string tag, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s [%s] got %0d expected %0d at %0t", name, tag, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("count", e.tag, int'(count), e.count);
      chk("t_out", e.tag, int'(t_out), e.t_out);
      chk("tc",    e.tag, int'(tc),    e.tc);
      chk("wrap",  e.tag, int'(wrap),  e.wrap);
    end
  end

  // Apply one cycle of inputs, predict this cycle's outputs and the state after the edge.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input int lv, input string tag);
    exp_t x;
    int   nxt, tcv, wnext;
    rst_n = r; en = e; up = u; load = l; load_val = W'(lv);
    tcv = 0; wnext = 0; nxt = m_count;
    if (!r) begin
      nxt = 0;
    end else if (l) begin
      nxt = (lv < M) ? lv : M - 1;
    end else if (e) begin
      if (u) begin
        tcv = (m_count == M - 1);
        nxt = (m_count + 1) % M;
      end else begin
        tcv = (m_count == 0);
        nxt = (m_count + M - 1) % M;
      end
`ifdef TFF_COUNT_CTRL_SAT_EN
      if (tcv != 0) nxt = m_count;
`else
      wnext = tcv;
`endif
    end
    x.count = m_count;
    x.t_out = r ? (m_count ^ nxt) : 0;
    x.tc    = tcv;
    x.wrap  = m_wrap;
    x.tag   = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    m_count = nxt;
    m_wrap  = wnext;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
    @(posedge clk);
    #1;
    step(0, 1, 1, 1, 7, "reset");

    for (int i = 0; i < 11; i++) step(1, 1, 1, 0, 0, "up_wrap");

    step(1, 0, 1, 1, 0, "load0");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, "down_wrap");

    step(1, 1, 1, 1, 13, "load_clamp");
    step(1, 1, 1, 1, 3,  "load3");
    step(1, 0, 1, 0, 0,  "after_load");

    step(1, 0, 1, 1, 5, "load5");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, "hold");
    for (int i = 0; i < 4; i++) step(1, 1, (i % 2 == 0), 0, 0, "dir_flip");

    step(1, 0, 1, 1, 8, "load8");
    step(0, 1, 1, 0, 0, "mid_reset");
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, "resume");

    step(1, 0, 1, 1, 9, "load9");
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, "limit_up");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)), "random");
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain scoreboard still holds %0d entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
